// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the arbiter FSM state encoding and the round-robin pick function
// used for grant selection.
package uart_pkg;

  // Widest requester vector the pick function handles.
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Returns a one-hot vector selecting the first set bit of cand, searching
  // from (ptr+1) mod n upward with wrap. Returns zero when cand is empty.
  // ptr must be below n and n must lie in 1..MAX_REQ.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] cand,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [3:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (4'(i) <= n) begin
        idx = 4'(ptr) + 4'(i);
        // ptr < n, so a single wrap brings the index back into range.
        if (idx >= n) idx = idx - n;
        if (!found && cand[idx[2:0]]) begin
          pick[idx[2:0]] = 1'b1;
          found          = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_arb_oreg.sv
// Output register stage of the UART transmit arbiter.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   load_i           accepted input beat this cycle
//   data_i, last_i   beat contents from the granted requester
//   ready_i          downstream write buffer accepts
//   data_o, last_o   registered beat
//   valid_o          registered beat valid
module uart_arb_oreg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;

  // The arbiter only asserts load_i when the register is empty or draining,
  // so a load never overwrites a beat that has not been accepted.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      last_d  = last_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding a UART transmit write buffer.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   req_valid/data/last per-requester beat stream (requester i at slice i)
//   req_ready           per-requester accept, only the owner may be ready
//   en_mask             per-requester arbitration enable, used in IDLE only
//   data_o/last_o/valid_out, ready_out   registered output stream
//   grant_o             one-hot current owner, zero when idle
//   trunc_o             one-cycle pulse when a packet hits MAX_BEATS
//
// state    | meaning
// ST_IDLE  | no owner; pick next candidate after ptr
// ST_GRANT | owner forwards beats until last or MAX_BEATS
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            en_mask,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic                          last_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          trunc_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            trunc_q, trunc_d;

  logic [NUM_REQ-1:0]    cand;
  logic [MAX_REQ-1:0]    pick_ext;
  logic [PW-1:0]         pick_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  at_max;
  logic                  in_hs;
  logic                  oreg_last;

  assign cand     = req_valid & en_mask;
  assign pick_ext = rr_pick(MAX_REQ'(cand), 3'(ptr_q), 4'(NUM_REQ));
  assign sel_data = req_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = req_last[gidx_q];
  assign at_max   = (beat_q == BW'(MAX_BEATS - 1));

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_ext[i]) pick_idx = PW'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      gidx_q  <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      trunc_q <= trunc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    trunc_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (|cand) begin
          state_d = ST_GRANT;
          grant_d = pick_ext[NUM_REQ-1:0];
          gidx_d  = pick_idx;
        end
      end
      ST_GRANT: begin
        if (in_hs) begin
          beat_d = beat_q + BW'(1);
          if (sel_last || at_max) begin
            state_d = ST_IDLE;
            ptr_d   = gidx_q;
            grant_d = '0;
            trunc_d = at_max & ~sel_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    in_hs     = 1'b0;
    oreg_last = sel_last;
    if (state_q == ST_GRANT) begin
      req_ready = grant_q & {NUM_REQ{~valid_out | ready_out}};
      in_hs     = req_valid[gidx_q] & req_ready[gidx_q];
      // A truncated packet is closed downstream by forcing last on beat MAX_BEATS.
      oreg_last = sel_last | at_max;
    end
  end

  uart_arb_oreg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_oreg (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (in_hs),
    .data_i (sel_data),
    .last_i (oreg_last),
    .ready_i(ready_out),
    .data_o (data_o),
    .last_o (last_o),
    .valid_o(valid_out)
  );

  assign grant_o = grant_q;
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    en_mask;
  logic [DW-1:0]    data_o;
  logic             valid_out;
  logic             ready_out;
  logic             last_o;
  logic [NR-1:0]    grant_o;
  logic             trunc_o;

  uart_tx_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BEATS(MB)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .en_mask(en_mask),
    .data_o(data_o), .valid_out(valid_out), .ready_out(ready_out),
    .last_o(last_o), .grant_o(grant_o), .trunc_o(trunc_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [8:0]    src_q [NR][$];
  logic [8:0]    exp_q [$];
  logic [NR-1:0] grant_log [$];
  logic [NR-1:0] prev_grant = '0;
  int            trunc_cnt  = 0;
  logic          prev_stall = 1'b0;
  logic [8:0]    prev_beat  = '0;
  logic          saw_g3     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i]         = 1'b1;
        req_data[i*DW +: DW] = h[7:0];
        req_last[i]          = h[8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  // One clock: monitor at the falling edge, then update stimulus after the rising edge.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (rstn) begin
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'b0, data_o}, {24'b0, e[7:0]});
          check("out_last", {31'b0, last_o}, {31'b0, e[8]});
        end
      end
      if (valid_out && !ready_out) begin
        check("stall_ready", {28'b0, req_ready}, 0);
        if (prev_stall) check("stall_hold", {23'b0, last_o, data_o}, {23'b0, prev_beat});
      end
      prev_stall = valid_out && !ready_out;
      prev_beat  = {last_o, data_o};
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
      end
      if (grant_o != '0 && grant_o != prev_grant) grant_log.push_back(grant_o);
      prev_grant = grant_o;
      if (trunc_o) trunc_cnt++;
      if (grant_o[3]) saw_g3 = 1'b1;
      check("grant_onehot", {31'b0, ($countones(grant_o) <= 1)}, 1);
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int r, input logic [7:0] base, input int n, input bit last_end);
    for (int k = 0; k < n; k++) src_q[r].push_back({(last_end && k == n - 1), 8'(base + 8'(k))});
  endtask

  task automatic exp_pkt(input logic [7:0] base, input int n, input int last_at);
    for (int k = 0; k < n; k++) exp_q.push_back({(k == last_at), 8'(base + 8'(k))});
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (2) step();
  endtask

  task automatic wait_grant(input string tag, input logic [NR-1:0] g, input int budget);
    int n = 0;
    while (grant_o !== g && n < budget) begin
      step();
      n++;
    end
    check(tag, {28'b0, grant_o}, {28'b0, g});
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (valid_out !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'b0, valid_out}, 1);
  endtask

  initial begin
    rstn      = 1'b0;
    ready_out = 1'b1;
    en_mask   = '1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) step();
    rstn = 1'b1;

    // Idle after reset
    check("rst_data", {24'b0, data_o}, 0);
    check("rst_last", {31'b0, last_o}, 0);
    check("rst_trunc", {31'b0, trunc_o}, 0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_grant", {28'b0, grant_o}, 0);
      check("idle_valid", {31'b0, valid_out}, 0);
      check("idle_ready", {28'b0, req_ready}, 0);
    end

    // Two 3-byte packets, round robin from ptr=3
    grant_log.delete();
    add_pkt(0, 8'h11, 3, 1'b1);
    add_pkt(2, 8'hA1, 3, 1'b1);
    exp_pkt(8'h11, 3, 2);
    exp_pkt(8'hA1, 3, 2);
    drive();
    drain("rr2", 100);
    check("rr2_ngrants", grant_log.size(), 2);
    check("rr2_grant0", {28'b0, grant_log[0]}, 32'h1);
    check("rr2_grant1", {28'b0, grant_log[1]}, 32'h4);
    check("rr2_trunc", trunc_cnt, 0);

    // 20-beat packet from requester 1, truncated at 16; others jump ahead
    grant_log.delete();
    trunc_cnt = 0;
    add_pkt(1, 8'h40, 20, 1'b1);
    drive();
    wait_grant("trunc_first", 4'b0010, 20);
    add_pkt(2, 8'hB1, 1, 1'b1);
    add_pkt(3, 8'hC1, 1, 1'b1);
    drive();
    exp_pkt(8'h40, 16, 15);
    exp_pkt(8'hB1, 1, 0);
    exp_pkt(8'hC1, 1, 0);
    exp_pkt(8'h50, 4, 3);
    drain("trunc", 200);
    check("trunc_pulses", trunc_cnt, 1);
    check("trunc_ngrants", grant_log.size(), 4);
    check("trunc_grant0", {28'b0, grant_log[0]}, 32'h2);
    check("trunc_grant1", {28'b0, grant_log[1]}, 32'h4);
    check("trunc_grant2", {28'b0, grant_log[2]}, 32'h8);
    check("trunc_grant3", {28'b0, grant_log[3]}, 32'h2);

    // Backpressure for 5 cycles mid-packet
    add_pkt(0, 8'h61, 4, 1'b1);
    exp_pkt(8'h61, 4, 3);
    drive();
    wait_valid("bp_valid", 20);
    check("bp_first", {24'b0, data_o}, 32'h61);
    ready_out = 1'b0;
    repeat (5) step();
    check("bp_held", {24'b0, data_o}, 32'h61);
    ready_out = 1'b1;
    drain("bp", 100);

    // en_mask[3] cleared mid-packet
    grant_log.delete();
    add_pkt(3, 8'h71, 5, 1'b1);
    exp_pkt(8'h71, 5, 4);
    drive();
    wait_grant("mask_grant", 4'b1000, 20);
    step();
    en_mask = 4'b0111;
    drain("mask", 100);
    saw_g3 = 1'b0;
    add_pkt(3, 8'h81, 1, 1'b1);
    drive();
    repeat (20) step();
    check("mask_no_grant", {31'b0, saw_g3}, 0);
    check("mask_pending", src_q[3].size(), 1);
    check("mask_no_valid", {31'b0, valid_out}, 0);
    en_mask = '1;
    exp_pkt(8'h81, 1, 0);
    drain("unmask", 100);

    // Reset mid-packet discards the buffered beat
    add_pkt(2, 8'h91, 6, 1'b1);
    ready_out = 1'b0;
    drive();
    wait_valid("rstmid_valid", 20);
    check("rstmid_data", {24'b0, data_o}, 32'h91);
    rstn = 1'b0;
    step();
    check("rstmid_grant", {28'b0, grant_o}, 0);
    check("rstmid_valid0", {31'b0, valid_out}, 0);
    check("rstmid_last", {31'b0, last_o}, 0);
    check("rstmid_trunc", {31'b0, trunc_o}, 0);
    check("rstmid_data0", {24'b0, data_o}, 0);
    check("rstmid_ready", {28'b0, req_ready}, 0);
    rstn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
    ready_out = 1'b1;
    repeat (3) step();
    check("rstmid_quiet", {31'b0, valid_out}, 0);
    grant_log.delete();
    add_pkt(2, 8'h91, 6, 1'b1);
    exp_pkt(8'h91, 6, 5);
    drive();
    drain("restart", 100);
    check("restart_ngrants", grant_log.size(), 1);
    check("restart_grant", {28'b0, grant_log[0]}, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
